// File: rtl/dsp_hwtest_pkg.sv
// ============================================================================
// Module   : dsp_hwtest_pkg
// Brief    : Shared types, widths, seed and MISR taps for DSP hardware test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_hwtest_pkg;

  localparam int MISR_W = 64;
  localparam int Z_W    = 54;

  localparam logic [MISR_W-1:0] MISR_SEED = {MISR_W{1'b1}};

  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One MISR step: shift in the tap parity, then fold the raw Z bits in low.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                  input logic [Z_W-1:0]    zin);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[MISR_W-2:0], fb} ^ {{(MISR_W-Z_W){1'b0}}, zin};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_strobe_delay.sv
// ============================================================================
// Module   : dsp_strobe_delay
// Brief    : LAT-stage strobe delay line aligning strobe with valid DSP Z.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_strobe_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic strobe_o
);

  generate
    if (LAT == 0) begin : g_bypass
      assign strobe_o = strobe_i;
    end else begin : g_pipe
      logic [LAT-1:0] sr_q;
      logic [LAT-1:0] sr_d;

      if (LAT == 1) begin : g_single
        assign sr_d = strobe_i;
      end else begin : g_multi
        assign sr_d = {sr_q[LAT-2:0], strobe_i};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign strobe_o = sr_q[LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dsp_z_signature.sv
// ============================================================================
// Module   : dsp_z_signature
// Brief    : Folds NSAMP strobe-aligned DSP Z results into a 64-bit MISR.
// Config   : define DSP_ZSIG_LAST_EN to add the last_z capture port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_z_signature
  import dsp_hwtest_pkg::*;
#(
  parameter int NSAMP = 1024,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              strobe,
  input  logic [Z_W-1:0]    z,
  output logic [MISR_W-1:0] sig,
  output logic [15:0]       sample_cnt,
  output logic              busy,
  output logic              done
`ifdef DSP_ZSIG_LAST_EN
  ,
  output logic [Z_W-1:0]    last_z
`endif
);

  localparam logic [15:0] c_LAST_CNT = 16'(NSAMP);

  state_e              state_q, state_d;
  logic [MISR_W-1:0]   sig_q, sig_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                busy_q, done_q;
  logic                w_sample_en;

  dsp_strobe_delay #(
    .LAT (LAT)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (strobe),
    .strobe_o (w_sample_en)
  );

  // Samples are only folded in RUN; a start in IDLE/DONE wins over a sample.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (w_sample_en) begin
          sig_d = misr_step(sig_q, z);
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == c_LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          sig_d   = MISR_SEED;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign sig        = sig_q;
  assign sample_cnt = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef DSP_ZSIG_LAST_EN
  logic [Z_W-1:0] last_z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_z_q <= '0;
    end else if ((state_q == ST_RUN) && w_sample_en) begin
      last_z_q <= z;
    end
  end

  assign last_z = last_z_q;
`endif

endmodule

`default_nettype wire
